// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared definitions for the unified-memory port arbiter.
//   arbState_e   FSM encoding (IDLE / BUSY_IF / BUSY_DM)
//   OWNER_*      grant owner select values
//   ARB_*_W      default address/data widths
package mem_port_arbiter_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arbState_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt: counts data grants issued while a fetch is waiting.
//   clk, rst     clock, synchronous active-low reset
//   dmGrant      data access granted this cycle
//   ifGrant      fetch access granted this cycle (clears the count)
//   ifReq        fetch request pending
//   starved      count has reached STARVE_MAX; fetch must be granted next
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dmGrant,
  input  logic ifGrant,
  input  logic ifReq,
  output logic starved
);
  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                                  cnt <= '0;
    else if (ifGrant)                          cnt <= '0;
    else if (dmGrant && ifReq && cnt != 3'd7)  cnt <= cnt + 3'd1;
  end

  assign starved = (int'(cnt) >= STARVE_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between Fetch and Memory
// stages. Data has fixed priority over fetch; one access is outstanding at a
// time and is held on the mem_* side until mem_ready.
//   clk, rst                  clock, synchronous active-low reset
//   if_req/if_addr            fetch request (held until if_valid)
//   if_rdata/if_valid         fetched word + one-cycle valid
//   dm_req/we/addr/wdata      data request (held until dm_valid)
//   dm_rdata/dm_valid         load data + one-cycle completion (loads and stores)
//   flush                     discard an in-flight fetch
//   mem_req/we/addr/wdata     memory request side, held until mem_ready
//   mem_rdata/mem_ready       memory completion
//   stall_f/stall_m           pipeline freeze outputs
// Optional: define ARB_STARVE_GUARD_EN to force a fetch grant after
// STARVE_MAX data grants taken while fetch was waiting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_m
);
  arbState_e state, stateNext;
  logic      killQ;
  logic      grantValid, grantSel;
  logic      ifPending, dmPending, starved;

  // A requester whose valid is pulsing this cycle is still holding its old
  // request; it must not be granted a second time.
  assign ifPending = if_req & ~if_valid & ~flush;
  assign dmPending = dm_req & ~dm_valid;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) uStarveCnt (
    .clk     (clk),
    .rst     (rst),
    .dmGrant (grantValid && grantSel == OWNER_DM),
    .ifGrant (grantValid && grantSel == OWNER_IF),
    .ifReq   (if_req),
    .starved (starved)
  );
`else
  // Guard compiled out: constant 0 for any legal STARVE_MAX.
  assign starved = (STARVE_MAX < 0);
`endif

  always_comb begin
    stateNext  = state;
    grantValid = 1'b0;
    grantSel   = OWNER_DM;
    case (state)
      IDLE: begin
        if (ifPending && starved) begin
          grantValid = 1'b1;
          grantSel   = OWNER_IF;
          stateNext  = BUSY_IF;
        end else if (dmPending) begin
          grantValid = 1'b1;
          grantSel   = OWNER_DM;
          stateNext  = BUSY_DM;
        end else if (ifPending && !dm_req) begin
          // raw dm_req: a data stage finishing one access and issuing the
          // next back-to-back keeps priority over fetch
          grantValid = 1'b1;
          grantSel   = OWNER_IF;
          stateNext  = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: if (mem_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      killQ     <= 1'b0;
    end else begin
      state    <= stateNext;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      if (grantValid) begin
        mem_req <= 1'b1;
        if (grantSel == OWNER_DM) begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we   <= 1'b0;
          mem_addr <= if_addr;
        end
      end

      if (state == BUSY_IF) begin
        if (mem_ready) begin
          mem_req <= 1'b0;
          killQ   <= 1'b0;
          // a flush arriving with the completion also kills the fetch
          if (!(killQ || flush)) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end
        end else if (flush) begin
          killQ <= 1'b1;
        end
      end

      if (state == BUSY_DM && mem_ready) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        dm_valid <= 1'b1;
        if (!mem_we) dm_rdata <= mem_rdata;
      end
    end
  end

  assign stall_m = dm_req & ~dm_valid;
  assign stall_f = (if_req & ~if_valid) | stall_m;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Expected grants
// and read data are queued when a request is issued; a memory responder checks
// grants as it completes them and a monitor checks valid pulses.
module tb_mem_port_arbiter;
  logic        clk, rst;
  logic        if_req, dm_req, dm_we, flush, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, stall_f, stall_m;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  int          nVec = 0, nMis = 0;
  grant_t      grantQ[$];
  logic [31:0] ifQ[$], dmQ[$];
  logic [31:0] memArr[logic [31:0]];
  logic [31:0] lastIf = 0, lastDm = 0;
  bit          respEn = 0;
  int          memLat = 1, busyCnt = 0;
  grant_t      g;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memRd(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic expIf(input logic [31:0] a);
    grantQ.push_back('{addr: a, we: 1'b0, wdata: 32'd0});
    lastIf = memRd(a);
    ifQ.push_back(lastIf);
  endtask

  task automatic expDm(input logic we, input logic [31:0] a, input logic [31:0] wd);
    grantQ.push_back('{addr: a, we: we, wdata: wd});
    if (!we) lastDm = memRd(a);
    dmQ.push_back(lastDm);
  endtask

  // memory model: completes a request after memLat busy cycles
  always @(posedge clk) begin
    #1;
    if (respEn) begin
      if (mem_req && busyCnt >= memLat - 1) begin
        mem_ready = 1'b1;
        mem_rdata = memRd(mem_addr);
        busyCnt   = 0;
        if (grantQ.size() == 0) chk("grantSpurious", mem_addr, 32'hFFFF_FFFF);
        else begin
          g = grantQ.pop_front();
          chk("memAddr", mem_addr, g.addr);
          chk("memWe", 32'(mem_we), 32'(g.we));
          if (g.we) begin
            chk("memWdata", mem_wdata, g.wdata);
            memArr[mem_addr] = mem_wdata;
          end
        end
      end else begin
        mem_ready = 1'b0;
        if (mem_req) busyCnt++;
        else busyCnt = 0;
      end
    end
  end

  // valid-pulse monitor
  always @(negedge clk) begin
    if (if_valid) begin
      if (ifQ.size() == 0) chk("ifSpurious", 32'(if_valid), 32'd0);
      else chk("ifRdata", if_rdata, ifQ.pop_front());
    end
    if (dm_valid) begin
      if (dmQ.size() == 0) chk("dmSpurious", 32'(dm_valid), 32'd0);
      else chk("dmRdata", dm_rdata, dmQ.pop_front());
    end
  end

  task automatic runFetch(input logic [31:0] a);
    bit got = 0;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (if_valid) got = 1;
      else chk("stallF", 32'(stall_f), 32'd1);
    end
    if (!got) chk("ifTimeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic runData(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (dm_valid) got = 1;
      else chk("stallM", 32'(stall_m), 32'd1);
    end
    if (!got) chk("dmTimeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  // back-to-back loads with dm_req never dropping between them
  task automatic runLoadStream(input int n, input logic [31:0] base);
    dm_req = 1'b1; dm_we = 1'b0;
    for (int k = 0; k < n; k++) begin
      bit got = 0;
      dm_addr = base + 32'(4 * k);
      for (int i = 0; i < 80 && !got; i++) begin
        @(negedge clk);
        if (dm_valid) got = 1;
        else chk("stallMStream", 32'(stall_m), 32'd1);
      end
      if (!got) chk("dmStreamTimeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    dm_req = 1'b0;
  endtask

  task automatic waitMemReq();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    if (!got) chk("memReqTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    if_req = 0; dm_req = 0; dm_we = 0; flush = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    memArr[32'h40]  = 32'h8C22_0004;
    memArr[32'h44]  = 32'h1234_5678;
    memArr[32'h104] = 32'hCAFE_F00D;

    // reset with mem_ready asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstMemReq",   32'(mem_req),  0);
    chk("rstMemWe",    32'(mem_we),   0);
    chk("rstMemAddr",  mem_addr,      0);
    chk("rstMemWdata", mem_wdata,     0);
    chk("rstIfRdata",  if_rdata,      0);
    chk("rstDmRdata",  dm_rdata,      0);
    chk("rstIfValid",  32'(if_valid), 0);
    chk("rstDmValid",  32'(dm_valid), 0);
    chk("rstStallF",   32'(stall_f),  0);
    chk("rstStallM",   32'(stall_m),  0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idleReadyMemReq", 32'(mem_req), 0);
      chk("idleReadyValid",  32'({if_valid, dm_valid}), 0);
    end
    @(posedge clk); #1; mem_ready = 1'b0; respEn = 1;

    // single fetch, memory answers in the second busy cycle
    memLat = 2;
    expIf(32'h40);
    runFetch(32'h40);

    // single load
    memLat = 1;
    expDm(1'b0, 32'h104, 32'd0);
    runData(1'b0, 32'h104, 32'd0);

    // contention: store wins, fetch follows
    expDm(1'b1, 32'h100, 32'hDEAD_BEEF);
    expIf(32'h48);
    fork
      runData(1'b1, 32'h100, 32'hDEAD_BEEF);
      runFetch(32'h48);
    join

    // flush kills an in-flight fetch
    memLat = 3;
    grantQ.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'd0});
    if_req = 1'b1; if_addr = 32'h44;
    waitMemReq();
    @(posedge clk); #1; flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1; flush = 1'b0;
    repeat (4) @(negedge clk);
    chk("killIfRdata", if_rdata, lastIf);
    chk("killMemReq",  32'(mem_req), 0);
    chk("killStallF",  32'(stall_f), 0);

    // reset in the middle of a data access, then a stray mem_ready
    respEn = 0; memLat = 1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    waitMemReq();
    @(posedge clk); #1; rst = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    lastIf = 0; lastDm = 0;
    repeat (3) begin
      @(negedge clk);
      chk("midRstMemReq",  32'(mem_req),  0);
      chk("midRstDmValid", 32'(dm_valid), 0);
    end
    chk("midRstDmRdata", dm_rdata, 0);
    @(posedge clk); #1; mem_ready = 1'b0; respEn = 1;

    // continuous data stream while fetch waits
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) expDm(1'b0, 32'h300 + 32'(4 * k), 32'd0);
    expIf(32'h80);
    expDm(1'b0, 32'h310, 32'd0);
`else
    for (int k = 0; k < 5; k++) expDm(1'b0, 32'h300 + 32'(4 * k), 32'd0);
    expIf(32'h80);
`endif
    fork
      runLoadStream(5, 32'h300);
      runFetch(32'h80);
    join

    repeat (4) @(negedge clk);
    chk("grantQEmpty", 32'(grantQ.size()), 0);
    chk("ifQEmpty",    32'(ifQ.size()),    0);
    chk("dmQEmpty",    32'(dmQ.size()),    0);
    chk("endMemReq",   32'(mem_req),       0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
